pio_bank_commit: RTL and testbench
==================================

Name: pio_bank_commit

Overview:
- Parametrised successor to the single-channel Avalon-MM output PIO.
- Provides NCH output channels of width W, each behind a software-writable staging register.
- An atomic commit copies all staging registers to the live outputs and presents them to downstream FPGA logic over a valid/ready handshake.
- Sits on the HPS lightweight bus and drives solver parameters such as max_iter, coordinates and zoom, which must change together.

Parameters:
- W, 16: width of each channel; 1..32.
- NCH, 4: number of channels; 1..(2^ADDR_W - 2).
- ADDR_W, 3: Avalon word-address width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data.
- out_port  out  NCH*W  live values; channel i occupies bits [i*W +: W].
- out_valid  out  1  live values are new and not yet consumed.
- out_ready  in  1  downstream accepts.
- irq  out  1  only present with PIO_BANK_IRQ_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: staging, live, out_port, out_valid, auto, overrun and done all 0.
- A write is chipselect && !write_n. There are no wait states, and readdata is combinational from address.
- Register map:
  - 0..NCH-1: STAGE[i]. Write loads writedata[W-1:0]. Read returns staging zero-extended.
  - NCH: CTRL, write-only, reads 0.
    - bit0 COMMIT.
    - bit1 AUTO value, always loaded on any CTRL write.
    - bit2 CLR_OVR.
    - bit3 CLR_DONE.
  - NCH+1: STATUS, read-only.
    - bit0 out_valid.
    - bit1 auto.
    - bit2 overrun.
    - bit3 done.
  - Other addresses: read 0, writes ignored.
- Commit request (creq): CTRL write with bit0=1, or a STAGE write while auto=1.
- On an auto-mode STAGE write, the committed snapshot uses the new writedata for that channel.
- Commit accepted when creq && (!out_valid || out_ready):
  - live <= snapshot at the next edge.
  - out_valid <= 1.
  - out_port updates on the same edge, giving one-cycle latency from the write.
- Commit rejected when creq && out_valid && !out_ready:
  - live is unchanged.
  - overrun <= 1.
  - Staging still takes the write.
- Handshake without creq (out_valid && out_ready): out_valid <= 0 next edge and done <= 1.
- Handshake and accepted commit in the same cycle: out_valid stays 1, live takes the new snapshot, done <= 1.
- out_port is stable while out_valid=1 && !out_ready. out_ready is ignored while out_valid=0.
- Clearing overrun and done: CLR_OVR / CLR_DONE clear the flag unless a set event occurs in the same cycle; set wins.
- Asynchronous reset mid-handshake drops out_valid immediately and discards any pending value.

Optional Feature:
- Macro PIO_BANK_IRQ_EN.
- Defined:
  - irq port exists; irq = done & irq_mask, registered.
  - CTRL bit4 loads irq_mask on every CTRL write; reset 0.
  - STATUS bit4 reads irq_mask.
- Undefined: no irq port, no mask register, STATUS bit4 reads 0.

Decomposition:
- Package pio_bank_pkg holds:
  - CTRL/STATUS bit-index constants (COMMIT=0, AUTO=1, CLR_OVR=2, CLR_DONE=3, IRQ_MASK=4).
  - Offset functions: STAGE base 0, CTRL=NCH, STATUS=NCH+1.
- One sub-module is natural: pio_commit_hs, the holding valid/ready output stage.
  - Parameter DW=NCH*W.
  - Inputs: load, data_in, out_ready.
  - Outputs: out_valid, data_out, accepted, rejected, handshake.

Test Plan:
- Reset: assert reset_n=0 mid-run → out_port=0, out_valid=0, STATUS=0 asynchronously, before the next clk edge.
- Atomic commit: write STAGE0=0x1234, STAGE3=0xBEEF, then CTRL=0x1 with out_ready=0 → out_port changes only on the commit edge, to {0xBEEF,0,0,0x1234}, out_valid=1. Read STAGE3 → 0x0000BEEF.
- Overrun: with out_valid=1 and out_ready=0, write STAGE0=0x5555 then CTRL=0x1 → out_port unchanged, STATUS=0x5. Then write CTRL=0x4 → STATUS=0x1.
- Back-to-back: CTRL=0x1 in the same cycle as out_ready=1 → out_valid stays 1, live takes new staging, done=1, no overrun.
- Auto mode: CTRL=0x2, then write STAGE1=0x00AB with out_valid=0 → next edge out_port channel1=0x00AB, out_valid=1. Writing W=16 with writedata=0xFFFF0001 stores 0x0001.
- IRQ (macro defined): CTRL=0x10, commit, pulse out_ready → irq=1 one cycle after done. CTRL=0x18 → irq=0. Undefined build: STATUS bit4 always 0.

Source files
------------

// File: rtl/pio_bank_pkg.sv
// Shared constants, register-map helpers and types for the committed PIO bank.
package pio_bank_pkg;

    localparam int unsigned BUS_DW = 32;

    // CTRL write bits
    localparam int unsigned CTRL_COMMIT   = 0;
    localparam int unsigned CTRL_AUTO     = 1;
    localparam int unsigned CTRL_CLR_OVR  = 2;
    localparam int unsigned CTRL_CLR_DONE = 3;
    localparam int unsigned CTRL_IRQ_MASK = 4;

    typedef enum logic {
        HS_EMPTY = 1'b0,
        HS_FULL  = 1'b1
    } hs_state_e;

    // STATUS read layout, LSB first: valid, auto, overrun, done, irq_mask
    typedef struct packed {
        logic irq_mask;
        logic done;
        logic overrun;
        logic auto_mode;
        logic valid;
    } status_t;

    function automatic int unsigned stage_off(input int unsigned ch);
        return ch;
    endfunction

    function automatic int unsigned ctrl_off(input int unsigned nch);
        return nch;
    endfunction

    function automatic int unsigned status_off(input int unsigned nch);
        return nch + 1;
    endfunction

endpackage

// File: rtl/pio_bank_commit_if.sv
// Avalon-MM slave bus plus the valid/ready output stream of the PIO bank.
interface pio_bank_commit_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned NCH    = 4,
    parameter int unsigned W      = 16
);
    logic [ADDR_W-1:0]  address;
    logic               chipselect;
    logic               write_n;
    logic [31:0]        writedata;
    logic [31:0]        readdata;
    logic [NCH*W-1:0]   out_port;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_port, out_valid
    );

    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_port, out_valid
    );
endinterface

// File: rtl/pio_commit_hs.sv
// Holding valid/ready output stage: captures a snapshot on an accepted load
// and keeps it stable until the downstream handshake.
module pio_commit_hs
    import pio_bank_pkg::*;
#(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [DW-1:0] data_in,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] data_out,
    output logic          accepted,
    output logic          rejected,
    output logic          handshake
);

    hs_state_e state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= HS_EMPTY;
        else          state_q <= state_d;
    end

    // A load is taken whenever the slot is empty or being drained this cycle
    always_comb begin
        state_d   = state_q;
        accepted  = 1'b0;
        rejected  = 1'b0;
        handshake = 1'b0;
        case (state_q)
            HS_EMPTY: begin
                if (load) begin
                    accepted = 1'b1;
                    state_d  = HS_FULL;
                end
            end
            HS_FULL: begin
                handshake = out_ready;
                if (load) begin
                    accepted = out_ready;
                    rejected = !out_ready;
                end else if (out_ready) begin
                    state_d = HS_EMPTY;
                end
            end
            default: state_d = HS_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      data_out <= '0;
        else if (accepted) data_out <= data_in;
    end

    assign out_valid = (state_q == HS_FULL);

endmodule

// File: rtl/pio_bank_commit.sv
// Multi-channel output PIO with staging registers and atomic commit.
// Optional PIO_BANK_IRQ_EN adds a maskable done interrupt.
module pio_bank_commit
    import pio_bank_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter int unsigned NCH    = 4,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_bank_commit_if.slave     bus
`ifdef PIO_BANK_IRQ_EN
    ,
    output logic                 irq
`endif
);

    localparam int unsigned DW = NCH * W;
    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(ctrl_off(NCH));
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_off(NCH));

    logic [W-1:0]  stage_q [NCH];
    logic [DW-1:0] snapshot;
    logic [DW-1:0] live;
    logic          wr, stage_wr, ctrl_wr, creq;
    logic          valid, accepted, rejected, handshake;
    logic          auto_q, overrun_q, done_q, irq_mask;
    status_t       status;

    assign wr       = bus.chipselect && !bus.write_n;
    assign stage_wr = wr && (32'(bus.address) < NCH);
    assign ctrl_wr  = wr && (bus.address == CTRL_ADDR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NCH; i++) stage_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++)
                if (stage_wr && bus.address == ADDR_W'(stage_off(i)))
                    stage_q[i] <= bus.writedata[W-1:0];
        end
    end

    // Snapshot forwards the in-flight STAGE write so auto-mode commits see it
    always_comb begin
        snapshot = '0;
        for (int unsigned i = 0; i < NCH; i++)
            snapshot[i*W +: W] = (stage_wr && bus.address == ADDR_W'(stage_off(i)))
                               ? bus.writedata[W-1:0] : stage_q[i];
    end

    assign creq = (ctrl_wr && bus.writedata[CTRL_COMMIT]) || (stage_wr && auto_q);

    pio_commit_hs #(.DW(DW)) u_hs (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (creq),
        .data_in   (snapshot),
        .out_ready (bus.out_ready),
        .out_valid (valid),
        .data_out  (live),
        .accepted  (accepted),
        .rejected  (rejected),
        .handshake (handshake)
    );

    assign bus.out_port  = live;
    assign bus.out_valid = valid;

    // Sticky flags: a set event in the same cycle beats its clear bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_q    <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (ctrl_wr) auto_q <= bus.writedata[CTRL_AUTO];
            if (rejected)                                     overrun_q <= 1'b1;
            else if (ctrl_wr && bus.writedata[CTRL_CLR_OVR])  overrun_q <= 1'b0;
            if (handshake)                                    done_q <= 1'b1;
            else if (ctrl_wr && bus.writedata[CTRL_CLR_DONE]) done_q <= 1'b0;
        end
    end

`ifdef PIO_BANK_IRQ_EN
    logic irq_mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (ctrl_wr) irq_mask_q <= bus.writedata[CTRL_IRQ_MASK];
            irq <= done_q & irq_mask_q;
        end
    end

    assign irq_mask = irq_mask_q;
`else
    assign irq_mask = 1'b0;
`endif

    always_comb begin
        status           = '0;
        status.valid     = valid;
        status.auto_mode = auto_q;
        status.overrun   = overrun_q;
        status.done      = done_q;
        status.irq_mask  = irq_mask;
    end

    // CTRL and unmapped addresses read as zero
    always_comb begin
        bus.readdata = '0;
        for (int unsigned i = 0; i < NCH; i++)
            if (bus.address == ADDR_W'(stage_off(i)))
                bus.readdata = BUS_DW'(stage_q[i]);
        if (bus.address == STATUS_ADDR)
            bus.readdata = BUS_DW'(status);
    end

endmodule

// File: tb/tb_pio_bank_commit.sv
// Directed self-checking bench for pio_bank_commit (W=16, NCH=4, ADDR_W=3).
module tb_pio_bank_commit;

    localparam int unsigned W      = 16;
    localparam int unsigned NCH    = 4;
    localparam int unsigned ADDR_W = 3;
    localparam logic [2:0]  A_CTRL = 3'd4;
    localparam logic [2:0]  A_STAT = 3'd5;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] rd;

    pio_bank_commit_if #(.ADDR_W(ADDR_W), .NCH(NCH), .W(W)) bus ();

`ifdef PIO_BANK_IRQ_EN
    logic irq;
    pio_bank_commit #(.W(W), .NCH(NCH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq));
`else
    pio_bank_commit #(.W(W), .NCH(NCH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        bus.writedata = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // reset state
        check("rst_out_port", bus.out_port, 64'h0);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        bus_read(A_STAT, rd);
        check("rst_status", 64'(rd), 64'h0);

        // atomic commit: staging writes do not reach out_port until CTRL
        bus_write(3'd0, 32'h0000_1234);
        check("stage0_no_live", bus.out_port, 64'h0);
        bus_write(3'd3, 32'h0000_BEEF);
        check("stage3_no_live", bus.out_port, 64'h0);
        check("stage3_no_valid", 64'(bus.out_valid), 64'h0);
        bus_write(A_CTRL, 32'h1);
        check("commit_port", bus.out_port, 64'hBEEF_0000_0000_1234);
        check("commit_valid", 64'(bus.out_valid), 64'h1);
        bus_read(3'd3, rd);
        check("read_stage3", 64'(rd), 64'h0000_BEEF);
        bus_read(A_CTRL, rd);
        check("read_ctrl_zero", 64'(rd), 64'h0);

        // overrun: commit while holding and out_ready=0
        bus_write(3'd0, 32'h0000_5555);
        bus_write(A_CTRL, 32'h1);
        check("ovr_port_hold", bus.out_port, 64'hBEEF_0000_0000_1234);
        bus_read(A_STAT, rd);
        check("ovr_status", 64'(rd), 64'h5);
        bus_read(3'd0, rd);
        check("ovr_stage0_taken", 64'(rd), 64'h5555);
        bus_write(A_CTRL, 32'h4);
        bus_read(A_STAT, rd);
        check("clr_ovr_status", 64'(rd), 64'h1);

        // back-to-back: commit in the handshake cycle
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.address = A_CTRL; bus.writedata = 32'h1; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.out_ready = 1'b0;
        check("b2b_valid", 64'(bus.out_valid), 64'h1);
        check("b2b_port", bus.out_port, 64'hBEEF_0000_0000_5555);
        bus_read(A_STAT, rd);
        check("b2b_status", 64'(rd), 64'h9);

        // plain handshake drains the slot
        pulse_ready();
        check("hs_valid", 64'(bus.out_valid), 64'h0);
        check("hs_port_kept", bus.out_port, 64'hBEEF_0000_0000_5555);
        bus_write(A_CTRL, 32'h8);
        bus_read(A_STAT, rd);
        check("clr_done_status", 64'(rd), 64'h0);

        // out_ready ignored while idle
        pulse_ready();
        bus_read(A_STAT, rd);
        check("idle_ready_status", 64'(rd), 64'h0);

        // auto mode
        bus_write(A_CTRL, 32'h2);
        bus_read(A_STAT, rd);
        check("auto_status", 64'(rd), 64'h2);
        check("auto_no_commit", 64'(bus.out_valid), 64'h0);
        bus_write(3'd1, 32'h0000_00AB);
        check("auto_port", bus.out_port, 64'hBEEF_0000_00AB_5555);
        check("auto_valid", 64'(bus.out_valid), 64'h1);
        bus_write(3'd2, 32'hFFFF_0001);
        check("auto_rej_port", bus.out_port, 64'hBEEF_0000_00AB_5555);
        bus_read(A_STAT, rd);
        check("auto_rej_status", 64'(rd), 64'h7);
        bus_read(3'd2, rd);
        check("stage2_trunc", 64'(rd), 64'h0001);

        // overrun set beats a simultaneous CLR_OVR
        bus_write(A_CTRL, 32'h7);
        bus_read(A_STAT, rd);
        check("set_wins_status", 64'(rd), 64'h7);
        bus_write(A_CTRL, 32'h6);
        bus_read(A_STAT, rd);
        check("clr_ovr_auto", 64'(rd), 64'h3);

        // unmapped addresses
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, rd);
        check("read_addr6", 64'(rd), 64'h0);
        bus_read(3'd7, rd);
        check("read_addr7", 64'(rd), 64'h0);
        check("unmapped_port", bus.out_port, 64'hBEEF_0000_00AB_5555);

        // irq mask bit
        bus_write(A_CTRL, 32'h10);
        bus_read(A_STAT, rd);
`ifdef PIO_BANK_IRQ_EN
        check("mask_status", 64'(rd), 64'h11);
        check("irq_idle", 64'(irq), 64'h0);
        pulse_ready();
        check("irq_lag", 64'(irq), 64'h0);
        bus_read(A_STAT, rd);
        check("irq_done_status", 64'(rd), 64'h18);
        @(posedge clk); #1;
        check("irq_set", 64'(irq), 64'h1);
        bus_write(A_CTRL, 32'h18);
        @(posedge clk); #1;
        check("irq_clear", 64'(irq), 64'h0);
`else
        check("mask_status", 64'(rd), 64'h01);
        pulse_ready();
        bus_read(A_STAT, rd);
        check("done_status_nomask", 64'(rd), 64'h08);
`endif

        // async reset while holding a value
        bus_write(A_CTRL, 32'h1);
        check("pre_rst_port", bus.out_port, 64'hBEEF_0001_00AB_5555);
        check("pre_rst_valid", 64'(bus.out_valid), 64'h1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.address = A_STAT;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_port", bus.out_port, 64'h0);
        check("async_rst_valid", 64'(bus.out_valid), 64'h0);
        check("async_rst_status", 64'(bus.readdata), 64'h0);
`ifdef PIO_BANK_IRQ_EN
        check("async_rst_irq", 64'(irq), 64'h0);
`endif
        bus.out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd3, rd);
        check("rst_stage3", 64'(rd), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
